ps2_rx_framer: RTL
==================

PS2_RX_FRAMER -- requirements
Module: ps2_rx_framer

Interface
REQ-001 Parameter FILTER_LEN, default 8, consecutive equal samples required before a filtered PS/2 line changes value.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, CLK_I cycles without a filtered k_clk falling edge before an in-progress frame is aborted.
REQ-003 CLK_I  input  1  system clock; all logic on rising edge.
REQ-004 RST_N_I  input  1  reset, asynchronous assert, active-low.
REQ-005 k_clk  input  1  raw PS/2 clock from pad, asynchronous to CLK_I.
REQ-006 k_data  input  1  raw PS/2 data from pad, asynchronous to CLK_I.
REQ-007 rx_data  output  8  last accepted scancode byte, LSB first on wire.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 rx_ready  input  1  downstream consumer accepts rx_data when rx_valid&rx_ready at a CLK_I edge.
REQ-010 rx_err_parity  output  1  one-cycle pulse: frame discarded for bad parity.
REQ-011 rx_err_frame  output  1  one-cycle pulse: frame discarded for bad stop bit or timeout.
REQ-012 rx_overrun  output  1  one-cycle pulse: good frame dropped because holding register full.
REQ-013 busy  output  1  high while state is not IDLE.

Function
REQ-014 k_clk and k_data SHALL each pass through a 2-flop synchronizer, then a filter updating its output only after FILTER_LEN consecutive identical synchronized samples; filtered outputs reset to 1.
REQ-015 A falling edge SHALL be detected when filtered k_clk was 1 the previous cycle and is 0 this cycle; filtered k_data is sampled in that same cycle.
REQ-016 States SHALL be IDLE, DATA, PARITY, STOP; transitions occur only on detected falling edges or timeout.
REQ-017 IDLE: sampled 0 -> DATA with bit counter cleared; sampled 1 -> stay IDLE, no error.
REQ-018 DATA: shift sampled bit into bit position counter (LSB first); after 8th bit -> PARITY.
REQ-019 PARITY: store sampled bit -> STOP.
REQ-020 STOP: always -> IDLE; sampled 1 and parity good -> frame good; sampled 0 -> rx_err_frame pulse next cycle; stop 1 but parity bad -> rx_err_parity pulse next cycle.
REQ-021 Parity good SHALL mean XOR of 8 data bits and parity bit equals 1 (odd parity).
REQ-022 Good frame SHALL load rx_data and set rx_valid on the CLK_I edge following the stop-bit sampling cycle (latency 1 cycle).
REQ-023 rx_valid SHALL clear on an edge with rx_valid&rx_ready unless a good frame completes in the same cycle, in which case rx_data loads the new byte and rx_valid stays 1, no overrun.
REQ-024 Good frame completing while rx_valid=1 and rx_ready=0 SHALL be dropped, rx_data unchanged, rx_overrun pulsed one cycle.
REQ-025 Timeout counter SHALL clear on every detected falling edge and in IDLE; reaching TIMEOUT_CYCLES in DATA/PARITY/STOP SHALL force IDLE and pulse rx_err_frame one cycle; counter saturates, never wraps.
REQ-026 At most one of rx_err_parity, rx_err_frame, rx_overrun SHALL be high in any cycle.

Reset
REQ-027 Asserting RST_N_I low SHALL immediately force: state IDLE, counters 0, synchronizer/filter outputs 1, rx_data 0x00, rx_valid/busy/all error pulses 0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no error pulse; after release the next start bit begins a fresh frame.

Configuration
REQ-029 Macro PS2_RX_PARITY_CHECK_EN defined: parity evaluated per REQ-020/021.
REQ-030 Macro PS2_RX_PARITY_CHECK_EN undefined: parity bit sampled but ignored, parity treated good, rx_err_parity tied 0.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1, rx_ready=1 -> rx_valid one cycle, rx_data=0x1C, no error pulses.
REQ-032 Frame 0xF0 with parity 0 (wrong) -> rx_err_parity one pulse, rx_valid stays 0 (macro defined); rx_data=0xF0 valid (macro undefined).
REQ-033 rx_ready=0, frames 0x1C then 0x32 -> rx_data=0x1C held, rx_overrun one pulse at second frame end.
REQ-034 Start bit plus 4 data bits then k_clk held high TIMEOUT_CYCLES -> rx_err_frame one pulse, busy 0, next full frame 0x1C received correctly.
REQ-035 k_clk glitch low for FILTER_LEN-1 cycles in IDLE -> no state change, busy 0.
REQ-036 RST_N_I pulsed low after 5 data bits -> all outputs at reset values asynchronously, subsequent frame 0x32 received correctly.

Source files
------------

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host receiver: synchronizes and deglitches k_clk/k_data, frames 11-bit words into bytes.
// Optional build macro PS2_RX_PARITY_CHECK_EN enables odd-parity checking; without it the parity bit is ignored.
module ps2_rx_framer #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  input  logic       k_clk,
  input  logic       k_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err_parity,
  output logic       rx_err_frame,
  output logic       rx_overrun,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // Lane 0 carries k_clk, lane 1 carries k_data.
  logic [1:0]    raw_s;
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] flt_cnt_q [2];
  logic          clk_prev_q;
  logic          fall_s, bit_s, timeout_s;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          good_s, ferr_s, ovr_s;
  logic          ferr_q, ovr_q;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic          par_q, par_d, perr_s, perr_q;
`endif

  assign raw_s = {k_data, k_clk};

  // Two-flop synchronizers followed by a run-length filter per line.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw_s;
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == FLT_LAST) begin
          filt_q[i]    <= sync2_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + FW'(1);
        end
      end
    end
  end

  assign fall_s    = clk_prev_q & ~filt_q[0];
  assign bit_s     = filt_q[1];
  // A falling edge in the same cycle wins over an expiring timeout.
  assign timeout_s = (state_q != IDLE) && !fall_s && (to_cnt_q == TO_MAX);

  // Frame FSM next-state, timeout counter and holding-register control.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    good_s     = 1'b0;
    ferr_s     = 1'b0;
    ovr_s      = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    par_d      = par_q;
    perr_s     = 1'b0;
`endif

    if (state_q == IDLE || fall_s) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    if (timeout_s) begin
      state_d = IDLE;
      ferr_s  = 1'b1;
    end else if (fall_s) begin
      case (state_q)
        IDLE: begin
          if (!bit_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = bit_s;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
          par_d = bit_s;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!bit_s) begin
            ferr_s = 1'b1;
`ifdef PS2_RX_PARITY_CHECK_EN
          end else if (^{shift_q, par_q}) begin
            good_s = 1'b1;
          end else begin
            perr_s = 1'b1;
          end
`else
          end else begin
            good_s = 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    if (good_s && rx_valid_q && !rx_ready) begin
      ovr_s = 1'b1;
    end else if (good_s) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // State, datapath and one-cycle status pulse registers.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      to_cnt_q   <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_s;
      ovr_q      <= ovr_s;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q      <= par_d;
      perr_q     <= perr_s;
`endif
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_err_frame = ferr_q;
  assign rx_overrun   = ovr_q;
  assign busy         = (state_q != IDLE);
`ifdef PS2_RX_PARITY_CHECK_EN
  assign rx_err_parity = perr_q;
`else
  assign rx_err_parity = 1'b0;
`endif

endmodule
